data_mem_stage: RTL and testbench

DATA_MEM_STAGE -- requirements
Module: data_mem_stage

---
 rtl/data_mem_stage.sv | 107 ++++++++++
 tb/tb_data_mem_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_stage.sv
// MEM pipeline stage: small word-addressed data RAM with a fixed per-access wait
// count, alignment/range fault detection and the MEM/WB pipeline register.
module data_mem_stage #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_mem_regwrite,
  input  logic [1:0]  ex_mem_reg_wb_enc,
  input  logic [31:0] ex_mem_reg_arithmetic_result,
  input  logic [31:0] ex_mem_reg_store_data,
  input  logic        ex_mem_memread,
  input  logic        ex_mem_memwrite,
  input  logic [7:0]  mem_instruct,
  output logic        mem_wb_regwrite,
  output logic [1:0]  mem_wb_reg_wb_enc,
  output logic [31:0] mem_wb_reg_arithmetic_result,
  output logic [7:0]  wb_instruct,
  output logic        mem_stall,
  output logic        mem_fault
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_CYCLES);

  logic              w_mem_op;
  logic              w_fault;
  logic              w_stall;
  logic              w_store;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_addr;

  logic [3:0]        r_cnt;
  logic              r_fault;
  logic              r_regwrite;
  logic [1:0]        r_wb_enc;
  logic [31:0]       r_result;
  logic [7:0]        r_instruct;
  logic [31:0]       r_ram [DEPTH];

  assign w_addr   = ex_mem_reg_arithmetic_result;
  assign w_idx    = w_addr[ADDR_W+1:2];
  assign w_mem_op = ex_mem_memread | ex_mem_memwrite;

  always_comb begin
    w_fault = 1'b0;
    if (w_mem_op) begin
      w_fault = (w_addr[1:0] != 2'b00)
              | ((w_addr >> (ADDR_W + 2)) != '0)
              | (ex_mem_memread & ex_mem_memwrite);
    end
  end

  // Gated by resetn so the stall drops the moment reset clears the counter,
  // even though the aborted request is still presented upstream.
  assign w_stall = resetn & w_mem_op & ~w_fault & (r_cnt != WAIT_CNT);
  assign w_store = w_mem_op & ex_mem_memwrite & ~w_fault & ~w_stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt      <= '0;
      r_fault    <= 1'b0;
      r_regwrite <= 1'b0;
      r_wb_enc   <= '0;
      r_result   <= '0;
      r_instruct <= '0;
    end else if (w_stall || w_fault) begin
      r_regwrite <= 1'b0;
      r_wb_enc   <= '0;
      r_result   <= '0;
      r_instruct <= '0;
      r_cnt      <= w_stall ? r_cnt + 4'd1 : '0;
      if (w_fault) r_fault <= 1'b1;
    end else begin
      r_cnt      <= '0;
      r_wb_enc   <= ex_mem_reg_wb_enc;
      r_instruct <= mem_instruct;
      if (ex_mem_memwrite) begin
        r_regwrite <= 1'b0;
        r_result   <= w_addr;
      end else if (ex_mem_memread) begin
        r_regwrite <= ex_mem_regwrite;
        r_result   <= r_ram[w_idx];
      end else begin
        r_regwrite <= ex_mem_regwrite;
        r_result   <= w_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_ram[i] <= '0;
    end else if (w_store) begin
      r_ram[w_idx] <= ex_mem_reg_store_data;
    end
  end

  assign mem_wb_regwrite              = r_regwrite;
  assign mem_wb_reg_wb_enc            = r_wb_enc;
  assign mem_wb_reg_arithmetic_result = r_result;
  assign wb_instruct                  = r_instruct;
  assign mem_stall                    = w_stall;
  assign mem_fault                    = r_fault;

endmodule

// File: tb/tb_data_mem_stage.sv
// Scoreboard bench for data_mem_stage: one instance with two wait cycles and one
// with none, driven from shared inputs; each has its own expected-response queue.
module tb_data_mem_stage;

  typedef logic [44:0] exp_t; // {stall, regwrite, enc[1:0], result[31:0], instr[7:0], fault}

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_mem_regwrite;
  logic [1:0]  ex_mem_reg_wb_enc;
  logic [31:0] ex_mem_reg_arithmetic_result;
  logic [31:0] ex_mem_reg_store_data;
  logic        ex_mem_memread;
  logic        ex_mem_memwrite;
  logic [7:0]  mem_instruct;

  logic        a_rw, b_rw, a_stall, b_stall, a_fault, b_fault;
  logic [1:0]  a_enc, b_enc;
  logic [31:0] a_res, b_res;
  logic [7:0]  a_ins, b_ins;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_stage #(.ADDR_W(4), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .resetn(resetn),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_reg_wb_enc(ex_mem_reg_wb_enc),
    .ex_mem_reg_arithmetic_result(ex_mem_reg_arithmetic_result),
    .ex_mem_reg_store_data(ex_mem_reg_store_data),
    .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
    .mem_instruct(mem_instruct),
    .mem_wb_regwrite(a_rw), .mem_wb_reg_wb_enc(a_enc),
    .mem_wb_reg_arithmetic_result(a_res), .wb_instruct(a_ins),
    .mem_stall(a_stall), .mem_fault(a_fault)
  );

  data_mem_stage #(.ADDR_W(4), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .resetn(resetn),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_reg_wb_enc(ex_mem_reg_wb_enc),
    .ex_mem_reg_arithmetic_result(ex_mem_reg_arithmetic_result),
    .ex_mem_reg_store_data(ex_mem_reg_store_data),
    .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
    .mem_instruct(mem_instruct),
    .mem_wb_regwrite(b_rw), .mem_wb_reg_wb_enc(b_enc),
    .mem_wb_reg_arithmetic_result(b_res), .wb_instruct(b_ins),
    .mem_stall(b_stall), .mem_fault(b_fault)
  );

  task automatic compare(input string name, input int n, input exp_t got, input exp_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s entry %0d: got stall=%b rw=%b enc=%0d res=%h ins=%h fault=%b, expected stall=%b rw=%b enc=%0d res=%h ins=%h fault=%b",
               name, n, got[44], got[43], got[42:41], got[40:9], got[8:1], got[0],
               exp[44], exp[43], exp[42:41], exp[40:9], exp[8:1], exp[0]);
    end
  endtask

  // Monitors: stall sampled mid-cycle (before the edge it governs), MEM/WB 1ns after that edge.
  initial begin : mon_a
    logic s;
    int n = 0;
    forever begin
      @(negedge clk); s = a_stall;
      @(posedge clk); #1;
      if (q_a.size() != 0) begin
        compare("dutA", n, {s, a_rw, a_enc, a_res, a_ins, a_fault}, q_a.pop_front());
        n++;
      end
    end
  end

  initial begin : mon_b
    logic s;
    int n = 0;
    forever begin
      @(negedge clk); s = b_stall;
      @(posedge clk); #1;
      if (q_b.size() != 0) begin
        compare("dutB", n, {s, b_rw, b_enc, b_res, b_ins, b_fault}, q_b.pop_front());
        n++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic push(input bit sel, input exp_t e);
    if (sel) q_b.push_back(e); else q_a.push_back(e);
  endtask

  // Holds one instruction for nstall+1 cycles; expected values supplied by the caller.
  task automatic op(input bit sel, input logic rw, input logic [1:0] enc, input logic [31:0] addr,
                    input logic [31:0] sd, input logic rd, input logic wr, input logic [7:0] ins,
                    input int nstall, input bit bub, input logic exp_rw, input logic [31:0] exp_res,
                    input logic f);
    for (int i = 0; i <= nstall; i++) begin
      cyc();
      ex_mem_regwrite = rw; ex_mem_reg_wb_enc = enc; ex_mem_reg_arithmetic_result = addr;
      ex_mem_reg_store_data = sd; ex_mem_memread = rd; ex_mem_memwrite = wr; mem_instruct = ins;
      if (i < nstall)  push(sel, {1'b1, 1'b0, 2'd0, 32'd0, 8'd0, f});
      else if (bub)    push(sel, {1'b0, 1'b0, 2'd0, 32'd0, 8'd0, f});
      else             push(sel, {1'b0, exp_rw, enc, exp_res, ins, f});
    end
  endtask

  task automatic idle_inputs();
    ex_mem_regwrite = 1'b0; ex_mem_reg_wb_enc = 2'd0; ex_mem_reg_arithmetic_result = '0;
    ex_mem_reg_store_data = '0; ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0; mem_instruct = '0;
  endtask

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    resetn = 1'b0;
    idle_inputs();

    // dutA (WAIT_CYCLES=2): state while in reset
    cyc(); push(0, '0);
    cyc(); resetn = 1'b1;
    //        sel rw enc addr          sd            rd wr ins    ns bub erw eres          f
    op(0, 1, 2'd1, 32'h5,  32'h0,        0, 0, 8'h11, 0, 0, 1, 32'h5,        0);
    op(0, 1, 2'd2, 32'h8,  32'hDEADBEEF, 0, 1, 8'h22, 2, 0, 0, 32'h8,        0);
    op(0, 1, 2'd0, 32'h8,  32'h0,        1, 0, 8'h33, 2, 0, 1, 32'hDEADBEEF, 0);
    op(0, 1, 2'd3, 32'h4,  32'h0,        1, 0, 8'h44, 2, 0, 1, 32'h0,        0);
    op(0, 1, 2'd1, 32'h6,  32'h0,        1, 0, 8'h55, 0, 1, 0, 32'h0,        1);
    op(0, 1, 2'd2, 32'h40, 32'h0,        1, 0, 8'h66, 0, 1, 0, 32'h0,        1);
    op(0, 1, 2'd1, 32'hC,  32'h12345678, 1, 1, 8'h67, 0, 1, 0, 32'h0,        1);
    op(0, 1, 2'd3, 32'h1234, 32'h0,      0, 0, 8'h77, 0, 0, 1, 32'h1234,     1);
    op(0, 1, 2'd1, 32'h8,  32'h0,        1, 0, 8'h88, 2, 0, 1, 32'hDEADBEEF, 1);
    op(0, 1, 2'd0, 32'h3C, 32'hA5A50F0F, 0, 1, 8'hC1, 2, 0, 0, 32'h3C,       1);
    op(0, 1, 2'd1, 32'h3C, 32'h0,        1, 0, 8'hC2, 2, 0, 1, 32'hA5A50F0F, 1);

    // Store aborted by reset after one wait cycle; its target word must stay 0
    op(0, 0, 2'd1, 32'h10, 32'hCAFEF00D, 0, 1, 8'h99, 0, 1, 0, 32'h0,        1);
    q_a.pop_back();
    q_a.push_back({1'b1, 1'b0, 2'd0, 32'd0, 8'd0, 1'b1});
    cyc(); resetn = 1'b0; push(0, '0);
    cyc(); resetn = 1'b1; idle_inputs();
    push(0, '0);
    op(0, 1, 2'd2, 32'h10, 32'h0,        1, 0, 8'hAA, 2, 0, 1, 32'h0,        0);
    op(0, 1, 2'd2, 32'h8,  32'h0,        1, 0, 8'hAB, 2, 0, 1, 32'h0,        0);
    cyc(); idle_inputs(); push(0, '0);
    cyc();
    cyc();

    // dutB (WAIT_CYCLES=0): back-to-back accesses, never stalls
    resetn = 1'b0; push(1, '0);
    cyc(); resetn = 1'b1;
    op(1, 1, 2'd1, 32'h4,  32'h11112222, 0, 1, 8'hB1, 0, 0, 0, 32'h4,        0);
    op(1, 1, 2'd2, 32'h4,  32'h0,        1, 0, 8'hB2, 0, 0, 1, 32'h11112222, 0);
    op(1, 1, 2'd3, 32'h4,  32'h33334444, 0, 1, 8'hB3, 0, 0, 0, 32'h4,        0);
    op(1, 1, 2'd0, 32'h4,  32'h0,        1, 0, 8'hB4, 0, 0, 1, 32'h33334444, 0);
    op(1, 1, 2'd0, 32'h3C, 32'h0,        1, 0, 8'hB5, 0, 0, 1, 32'h0,        0);
    op(1, 1, 2'd1, 32'h5,  32'h0,        1, 0, 8'hB6, 0, 1, 0, 32'h0,        1);
    op(1, 0, 2'd2, 32'hABC, 32'h0,       0, 0, 8'hB7, 0, 0, 0, 32'hABC,      1);
    cyc(); idle_inputs();
    cyc();
    cyc();

    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left unchecked, expected 0/0", q_a.size(), q_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
